y86_decode_writeback: RTL and testbench

- Register-file stage feeding the execute stage of the sequential Y86-64 core.
- Combinationally decodes the source and destination register IDs from icode/rA/rB/cnd, and drives valA/valB into execute.
- On the rising clock edge, commits valE (ALU result, gated by cnd for cmovXX) and valM (memory load) back into the 15-entry register file.
- Together with execute, closes the SEQ datapath loop: execute consumes valA/valB and produces valE/cnd; this block consumes valE/cnd and produces valA/valB.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/y86_regfile.sv | 60 ++++++
 rtl/y86_decode_writeback.sv | 130 +++++++++++++
 tb/tb_y86_decode_writeback.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs, datapath width
// and a register-ID validity helper used by the decode/writeback stage.
package y86_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // A register ID names real storage only if it is not RNONE and lies inside the file.
    function automatic logic reg_valid(input logic [3:0] id, input int nregs);
        return (id != RNONE) && (int'(id) < nregs);
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: combinational read ports, two write ports (M beats E on the
// same address), async active-low reset. REGFILE_DBG_PORT_EN adds a third read port.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int                 DATA_W   = y86_pkg::DATA_W,
    parameter int                 NREGS    = 15,
    parameter int                 RSP_ID   = 4,
    parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
`ifdef REGFILE_DBG_PORT_EN
    input  logic [3:0]        raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg,
`endif
    input  logic              we_e,
    input  logic [3:0]        waddr_e,
    input  logic [DATA_W-1:0] wdata_e,
    input  logic              we_m,
    input  logic [3:0]        waddr_m,
    input  logic [DATA_W-1:0] wdata_m
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Reads see pre-edge contents only; there is deliberately no write bypass.
    assign rdata_a = reg_valid(raddr_a, NREGS) ? regs_q[raddr_a] : '0;
    assign rdata_b = reg_valid(raddr_b, NREGS) ? regs_q[raddr_b] : '0;
`ifdef REGFILE_DBG_PORT_EN
    assign rdata_dbg = reg_valid(raddr_dbg, NREGS) ? regs_q[raddr_dbg] : '0;
`endif

    always_comb begin
        regs_d = regs_q;
        if (we_e && reg_valid(waddr_e, NREGS)) begin
            regs_d[waddr_e] = wdata_e;
        end
        // Applied second so a load wins over the ALU result (popq %rsp).
        if (we_m && reg_valid(waddr_m, NREGS)) begin
            regs_d[waddr_m] = wdata_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/y86_decode_writeback.sv
// SEQ decode/writeback stage: decodes srcA/srcB/dstE/dstM, reads valA/valB and commits
// valE/valM on the rising edge. Optional debug read port under REGFILE_DBG_PORT_EN.
module y86_decode_writeback
    import y86_pkg::*;
#(
    parameter int                 DATA_W   = y86_pkg::DATA_W,
    parameter int                 NREGS    = 15,
    parameter int                 RSP_ID   = 4,
    parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
`ifdef REGFILE_DBG_PORT_EN
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [15:0]       wr_cnt
);

    localparam logic [3:0] RSP_REG = 4'(RSP_ID);

    logic        we_e;
    logic        we_m;
    logic [15:0] wr_cnt_d;
    logic [15:0] wr_cnt_q;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            IRRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            IIRMOVQ: dstE = rB;
            IRMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            IMRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            IOPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            ICALL: begin
                srcB = RSP_REG;
                dstE = RSP_REG;
            end
            IRET: begin
                srcA = RSP_REG;
                srcB = RSP_REG;
                dstE = RSP_REG;
            end
            IPUSHQ: begin
                srcA = rA;
                srcB = RSP_REG;
                dstE = RSP_REG;
            end
            IPOPQ: begin
                srcA = RSP_REG;
                srcB = RSP_REG;
                dstE = RSP_REG;
                dstM = rA;
            end
            IHALT, INOP, IJXX: ;
            default: ;
        endcase
    end

    // Each port counts separately, so a colliding popq %rsp still adds two.
    always_comb begin
        we_e     = in_valid && (dstE != RNONE);
        we_m     = in_valid && (dstM != RNONE);
        wr_cnt_d = wr_cnt_q + {15'b0, we_e} + {15'b0, we_m};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

    y86_regfile #(
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .RSP_ID   (RSP_ID),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (srcA),
        .raddr_b   (srcB),
        .rdata_a   (valA),
        .rdata_b   (valB),
`ifdef REGFILE_DBG_PORT_EN
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data),
`endif
        .we_e      (we_e),
        .waddr_e   (dstE),
        .wdata_e   (valE),
        .we_m      (we_m),
        .waddr_m   (dstM),
        .wdata_m   (valM)
    );

endmodule

// File: tb/tb_y86_decode_writeback.sv
// Bench for y86_decode_writeback: directed vector table, reset corners, randomized
// traffic against an architectural register-file model, and wr_cnt wraparound.
module tb_y86_decode_writeback;

    localparam logic [63:0] RSP_INIT = 64'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid;
    logic [3:0]  icode, ra_i, rb_i;
    logic        cnd;
    logic [63:0] val_e, val_m;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b;
    logic [15:0] wr_cnt;
`ifdef REGFILE_DBG_PORT_EN
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
`endif

    y86_decode_writeback #(
        .DATA_W   (64),
        .NREGS    (15),
        .RSP_ID   (4),
        .RSP_INIT (RSP_INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .icode    (icode),
        .rA       (ra_i),
        .rB       (rb_i),
        .cnd      (cnd),
        .valE     (val_e),
        .valM     (val_m),
`ifdef REGFILE_DBG_PORT_EN
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
`endif
        .srcA     (src_a),
        .srcB     (src_b),
        .dstE     (dst_e),
        .dstM     (dst_m),
        .valA     (val_a),
        .valB     (val_b),
        .wr_cnt   (wr_cnt)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_regs [15];
    logic [15:0] m_cnt;

    function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb,
                                           input logic c);
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic inside {4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] id);
        return (id == 4'hF) ? 64'h0 : m_regs[id];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? RSP_INIT : 64'h0;
        m_cnt = 16'h0;
    endtask

    task automatic m_commit();
        logic [3:0] de, dm;
        de = m_dst_e(icode, rb_i, cnd);
        dm = m_dst_m(icode, ra_i);
        if (in_valid) begin
            if (de != 4'hF) begin m_regs[de] = val_e; m_cnt = m_cnt + 16'd1; end
            if (dm != 4'hF) begin m_regs[dm] = val_m; m_cnt = m_cnt + 16'd1; end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c, input logic [63:0] e,
                         input logic [63:0] m);
        in_valid = v; icode = ic; ra_i = ra; rb_i = rb; cnd = c; val_e = e; val_m = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-writing rmmovq-shaped read of register r on both read ports.
    task automatic read_reg(input logic [3:0] r, input logic [63:0] exp, input string name);
        drive(1'b0, 4'h4, r, r, 1'b0, 64'h0, 64'h0);
        #1;
        check({name, ".valA"}, val_a, exp);
        check({name, ".valB"}, val_b, exp);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [3:0]  ic, ra, rb;
        logic        c;
        logic [63:0] e, m;
        logic [3:0]  sa, sb, de, dm;
        logic [63:0] va, vb;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // irmovq, OPq read-back, cmov false/true, popq %rsp, invalid, undefined icode,
        // mrmovq, call, pushq.
        tbl[0] = '{1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0,
                   4'hF, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0, 16'd1};
        tbl[1] = '{1'b1, 4'h6, 4'h2, 4'h2, 1'b0, 64'h2468, 64'h0,
                   4'h2, 4'h2, 4'h2, 4'hF, 64'h1234, 64'h1234, 16'd2};
        tbl[2] = '{1'b1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'h0,
                   4'h1, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 16'd2};
        tbl[3] = '{1'b1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'h0,
                   4'h1, 4'hF, 4'h3, 4'hF, 64'h0, 64'h0, 16'd3};
        tbl[4] = '{1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABCD,
                   4'h4, 4'h4, 4'h4, 4'h4, 64'h100, 64'h100, 16'd5};
        tbl[5] = '{1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'hFF, 64'h0,
                   4'hF, 4'hF, 4'h5, 4'hF, 64'h0, 64'h0, 16'd5};
        tbl[6] = '{1'b1, 4'hC, 4'h1, 4'h2, 1'b1, 64'h77, 64'h88,
                   4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 16'd5};
        tbl[7] = '{1'b1, 4'h5, 4'h6, 4'h3, 1'b0, 64'h77, 64'h99,
                   4'hF, 4'h3, 4'hF, 4'h6, 64'h0, 64'h55, 16'd6};
        tbl[8] = '{1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'hF8, 64'h0,
                   4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'hABCD, 16'd7};
        tbl[9] = '{1'b1, 4'hA, 4'h6, 4'hF, 1'b0, 64'hF0, 64'h0,
                   4'h6, 4'h4, 4'h4, 4'hF, 64'h99, 64'hF8, 16'd8};

`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = 4'hF;
`endif
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();

        // Reset state
        check("reset.wr_cnt", {48'h0, wr_cnt}, 64'h0);
        for (int r = 0; r < 15; r++) begin
            read_reg(4'(r), (r == 4) ? RSP_INIT : 64'h0, $sformatf("reset.r%0d", r));
        end

        // Directed table
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].ic, tbl[i].ra, tbl[i].rb, tbl[i].c, tbl[i].e, tbl[i].m);
            #1;
            check($sformatf("tbl%0d.srcA", i), {60'h0, src_a}, {60'h0, tbl[i].sa});
            check($sformatf("tbl%0d.srcB", i), {60'h0, src_b}, {60'h0, tbl[i].sb});
            check($sformatf("tbl%0d.dstE", i), {60'h0, dst_e}, {60'h0, tbl[i].de});
            check($sformatf("tbl%0d.dstM", i), {60'h0, dst_m}, {60'h0, tbl[i].dm});
            check($sformatf("tbl%0d.valA", i), val_a, tbl[i].va);
            check($sformatf("tbl%0d.valB", i), val_b, tbl[i].vb);
            tick();
            check($sformatf("tbl%0d.wr_cnt", i), {48'h0, wr_cnt}, {48'h0, tbl[i].cnt});
        end
        read_reg(4'h1, 64'h0,    "post.r1");
        read_reg(4'h2, 64'h2468, "post.r2");
        read_reg(4'h3, 64'h55,   "post.r3");
        read_reg(4'h4, 64'hF0,   "post.rsp");
        read_reg(4'h5, 64'h0,    "post.r5");
        read_reg(4'h6, 64'h99,   "post.r6");
`ifdef REGFILE_DBG_PORT_EN
        dbg_addr = 4'h2;
        #1 check("dbg.r2", dbg_data, 64'h2468);
        dbg_addr = 4'hF;
        #1 check("dbg.rnone", dbg_data, 64'h0);
`endif

        // Reset asserted between edges clears state at once; no write survives it.
        tick();
        drive(1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'hAA, 64'h0);
        tick();
        read_reg(4'h7, 64'hAA, "mid.r7_written");
        #1;
        rst_n = 1'b0;
        #1;
        check("mid.wr_cnt", {48'h0, wr_cnt}, 64'h0);
        read_reg(4'h7, 64'h0,    "mid.r7");
        read_reg(4'h2, 64'h0,    "mid.r2");
        read_reg(4'h4, RSP_INIT, "mid.rsp");
        drive(1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'hBB, 64'h0);
        tick();
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        rst_n = 1'b1;
        m_reset();
        #1;
        check("mid.held_wr_cnt", {48'h0, wr_cnt}, 64'h0);
        read_reg(4'h7, 64'h0, "mid.held_r7");

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
`ifdef REGFILE_DBG_PORT_EN
            dbg_addr = 4'($urandom_range(0, 15));
`endif
            #1;
            check("rnd.srcA", {60'h0, src_a}, {60'h0, m_src_a(icode, ra_i)});
            check("rnd.srcB", {60'h0, src_b}, {60'h0, m_src_b(icode, rb_i)});
            check("rnd.dstE", {60'h0, dst_e}, {60'h0, m_dst_e(icode, rb_i, cnd)});
            check("rnd.dstM", {60'h0, dst_m}, {60'h0, m_dst_m(icode, ra_i)});
            check("rnd.valA", val_a, m_read(m_src_a(icode, ra_i)));
            check("rnd.valB", val_b, m_read(m_src_b(icode, rb_i)));
`ifdef REGFILE_DBG_PORT_EN
            check("rnd.dbg", dbg_data, m_read(dbg_addr));
`endif
            m_commit();
            tick();
            check("rnd.wr_cnt", {48'h0, wr_cnt}, {48'h0, m_cnt});
        end
        for (int r = 0; r < 15; r++) begin
            read_reg(4'(r), m_regs[r], $sformatf("rnd.final_r%0d", r));
        end

        // wr_cnt wraparound: popq %rsp adds two per edge, irmovq adds one.
        while (m_cnt != 16'hFFFF) begin
            if (16'hFFFF - m_cnt >= 16'd2)
                drive(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, {48'h0, m_cnt});
            else
                drive(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'h0);
            m_commit();
            tick();
        end
        check("wrap.pre", {48'h0, wr_cnt}, 64'hFFFF);
        drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
        m_commit();
        tick();
        check("wrap.post", {48'h0, wr_cnt}, {48'h0, m_cnt});
        check("wrap.zero", {48'h0, wr_cnt}, 64'h0);
        read_reg(4'h2, 64'h1234, "wrap.r2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
